// File: rtl/pmem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : pmem_loader_if
// Description : Byte-stream input and pmem write-port bundle for pmem_loader.
//               master : loader side  (consumes rx bytes, drives the write port)
//               slave  : system side  (drives rx bytes, observes the write port)
//   rx_data  [7:0]        received byte
//   rx_valid              rx_data valid this cycle
//   wea                   pmem write enable, one cycle per word
//   addra    [ADDR_W-1:0] pmem word address
//   dina     [31:0]       pmem write data
// Revision    : 1.0 - initial release
// ============================================================================
interface pmem_loader_if #(
  parameter int ADDR_W = 11
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [31:0]       dina;

  modport master (
    input  rx_data,
    input  rx_valid,
    output wea,
    output addra,
    output dina
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  wea,
    input  addra,
    input  dina
  );
endinterface
`default_nettype wire

// File: rtl/pmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : pmem_loader
// Description : Receives a framed byte stream (LEN_HI, LEN_LO, 4*N big-endian
//               data bytes, XOR checksum) and writes it as 32-bit words to
//               pmem addresses 0..N-1. Holds the CPU off through busy.
//   clka           system clock, rising edge
//   rsta_n         asynchronous active-low reset
//   start          one-cycle pulse, arms / re-arms a load (highest priority)
//   bus            byte stream in, pmem write port out (pmem_loader_if.master)
//   busy           load in progress (LEN_HI, LEN_LO, DATA, CHK)
//   done           load completed with good checksum, sticky until start
//   error          load rejected (bad length or checksum), sticky until start
//   words_written  words written in the current or last load
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_loader #(
  parameter int ADDR_W = 11
) (
  input  wire logic           clka,
  input  wire logic           rsta_n,
  input  wire logic           start,
  pmem_loader_if.master       bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_W:0]     words_written
);

  localparam int MAX_WORDS = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t            state,     state_nxt;
  logic [7:0]        len_hi,    len_hi_nxt;
  logic [ADDR_W:0]   n_words,   n_words_nxt;
  logic [ADDR_W:0]   word_cnt,  word_cnt_nxt;
  logic [1:0]        byte_cnt,  byte_cnt_nxt;
  logic [23:0]       asm_word,  asm_word_nxt;  // first three bytes of the word
  logic [7:0]        chk,       chk_nxt;
  logic              wea,       wea_nxt;
  logic [ADDR_W-1:0] addra,     addra_nxt;
  logic [31:0]       dina,      dina_nxt;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state    <= S_IDLE;
      len_hi   <= '0;
      n_words  <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_word <= '0;
      chk      <= '0;
      wea      <= 1'b0;
      addra    <= '0;
      dina     <= '0;
    end else begin
      state    <= state_nxt;
      len_hi   <= len_hi_nxt;
      n_words  <= n_words_nxt;
      word_cnt <= word_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
      asm_word <= asm_word_nxt;
      chk      <= chk_nxt;
      wea      <= wea_nxt;
      addra    <= addra_nxt;
      dina     <= dina_nxt;
    end
  end

  always_comb begin
    logic [15:0]     n;
    logic [ADDR_W:0] cnt_inc;

    state_nxt    = state;
    len_hi_nxt   = len_hi;
    n_words_nxt  = n_words;
    word_cnt_nxt = word_cnt;
    byte_cnt_nxt = byte_cnt;
    asm_word_nxt = asm_word;
    chk_nxt      = chk;
    wea_nxt      = 1'b0;          // write strobe lasts exactly one cycle
    addra_nxt    = addra;
    dina_nxt     = dina;
    n            = {len_hi, bus.rx_data};
    cnt_inc      = word_cnt + (ADDR_W+1)'(1);

    if (start) begin
      // Re-arm wins over any byte this cycle; a partial word is simply dropped
      // because the byte counter restarts and no write is issued.
      state_nxt    = S_LEN_HI;
      word_cnt_nxt = '0;
      byte_cnt_nxt = '0;
      chk_nxt      = '0;
    end else if (bus.rx_valid) begin
      unique case (state)
        S_LEN_HI: begin
          len_hi_nxt = bus.rx_data;
          state_nxt  = S_LEN_LO;
        end
        S_LEN_LO: begin
          if (n == 16'd0 || 32'(n) > MAX_WORDS) begin
            state_nxt = S_ERR;
          end else begin
            n_words_nxt = n[ADDR_W:0];
            state_nxt   = S_DATA;
          end
        end
        S_DATA: begin
          chk_nxt      = chk ^ bus.rx_data;
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            wea_nxt      = 1'b1;
            addra_nxt    = word_cnt[ADDR_W-1:0];
            dina_nxt     = {asm_word, bus.rx_data};
            word_cnt_nxt = cnt_inc;
            if (cnt_inc == n_words) begin
              state_nxt = S_CHK;
            end
          end else begin
            asm_word_nxt = {asm_word[15:0], bus.rx_data};
          end
        end
        S_CHK: begin
          state_nxt = (bus.rx_data == chk) ? S_DONE : S_ERR;
        end
        default: ;                // IDLE, DONE, ERR ignore bytes
      endcase
    end
  end

  assign bus.wea       = wea;
  assign bus.addra     = addra;
  assign bus.dina      = dina;
  assign busy          = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                         (state == S_DATA)   || (state == S_CHK);
  assign done          = (state == S_DONE);
  assign error         = (state == S_ERR);
  assign words_written = word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmem_loader
// Description : Self-checking bench for pmem_loader. Expected writes are
//               queued as stimulus is driven and compared by a write monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmem_loader;

  localparam int ADDR_W = 11;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } exp_t;

  logic              clka;
  logic              rsta_n;
  logic              start;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_written;

  int   checks;
  int   errors;
  int   n_writes;
  exp_t exp_q[$];

  pmem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  pmem_loader #(.ADDR_W(ADDR_W)) dut (
    .clka          (clka),
    .rsta_n        (rsta_n),
    .start         (start),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Write monitor: every wea cycle must match the next queued expectation.
  always @(negedge clka) begin
    if (bus.wea === 1'b1) begin
      exp_t e;
      n_writes = n_writes + 1;
      checks   = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_write: addr=%0d data=%h, required no write",
                 bus.addra, bus.dina);
      end else begin
        e = exp_q.pop_front();
        if (bus.addra !== e.a || bus.dina !== e.d) begin
          errors = errors + 1;
          $display("FAIL write_compare: got addr=%0d data=%h, required addr=%0d data=%h",
                   bus.addra, bus.dina, e.a, e.d);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clka);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clka);
    #1;
    start = 1'b0;
  endtask

  // Queues the expected write, then sends the word big-endian.
  task automatic send_word(input logic [31:0] w, input int addr,
                           inout logic [7:0] chk);
    exp_t e;
    e.a = addr[ADDR_W-1:0];
    e.d = w;
    exp_q.push_back(e);
    for (int i = 3; i >= 0; i--) begin
      chk = chk ^ w[i*8 +: 8];
      send_byte(w[i*8 +: 8]);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  task automatic test_reset();
    rsta_n = 1'b0;
    idle_cycles(3);
    checks = checks + 1;
    if ({bus.wea, bus.addra, bus.dina, busy, done, error, words_written} !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: wea=%b addra=%0d dina=%h busy=%b done=%b error=%b ww=%0d, required all 0",
               bus.wea, bus.addra, bus.dina, busy, done, error, words_written);
    end
    rsta_n = 1'b1;
    idle_cycles(2);
    checks = checks + 1;
    if (busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_idle_busy: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] chk = 8'h00;
    int         w0  = n_writes;
    pulse_start();
    checks = checks + 1;
    if (busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL good_busy_after_start: busy=%b, required 1", busy);
    end
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(32'h12345678, 0, chk);
    send_word(32'h9ABCDEF0, 1, chk);
    send_byte(chk);
    checks = checks + 1;
    if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || words_written !== 12'd2) begin
      errors = errors + 1;
      $display("FAIL good_status: done=%b error=%b busy=%b ww=%0d, required 1 0 0 2",
               done, error, busy, words_written);
    end
    idle_cycles(2);
    checks = checks + 1;
    if (n_writes - w0 != 2 || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL good_write_count: writes=%0d pending=%0d, required 2 0",
               n_writes - w0, exp_q.size());
    end
  endtask

  task automatic test_bad_chk();
    logic [7:0] chk = 8'h00;
    int         w0  = n_writes;
    pulse_start();
    checks = checks + 1;
    if (done !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL badchk_done_cleared: done=%b, required 0", done);
    end
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(32'h12345678, 0, chk);
    send_word(32'h9ABCDEF0, 1, chk);
    send_byte(chk ^ 8'h09);
    checks = checks + 1;
    if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL badchk_status: error=%b done=%b busy=%b, required 1 0 0",
               error, done, busy);
    end
    idle_cycles(2);
    checks = checks + 1;
    if (n_writes - w0 != 2 || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL badchk_write_count: writes=%0d pending=%0d, required 2 0",
               n_writes - w0, exp_q.size());
    end
  endtask

  task automatic test_bad_len(input logic [7:0] hi, input logic [7:0] lo);
    int w0 = n_writes;
    pulse_start();
    send_byte(hi);
    send_byte(lo);
    checks = checks + 1;
    if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL badlen_%h%h_status: error=%b busy=%b done=%b, required 1 0 0",
               hi, lo, error, busy, done);
    end
    // Data bytes after a rejected length must not produce writes.
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
    idle_cycles(2);
    checks = checks + 1;
    if (n_writes != w0) begin
      errors = errors + 1;
      $display("FAIL badlen_%h%h_nowrite: writes=%0d, required 0", hi, lo, n_writes - w0);
    end
  endtask

  task automatic test_full_memory();
    logic [7:0] chk = 8'h00;
    int         w0  = n_writes;
    pulse_start();
    send_byte(8'h08);
    send_byte(8'h00);
    for (int i = 0; i < 2048; i++) begin
      send_word(32'($urandom), i, chk);
    end
    checks = checks + 1;
    if (busy !== 1'b1 || words_written !== 12'd2048) begin
      errors = errors + 1;
      $display("FAIL full_before_chk: busy=%b ww=%0d, required 1 2048", busy, words_written);
    end
    send_byte(chk);
    idle_cycles(2);
    checks = checks + 1;
    if (done !== 1'b1 || error !== 1'b0 || n_writes - w0 != 2048 || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL full_status: done=%b error=%b writes=%0d pending=%0d, required 1 0 2048 0",
               done, error, n_writes - w0, exp_q.size());
    end
  endtask

  task automatic test_start_abort();
    logic [7:0] chk = 8'h00;
    int         w0  = n_writes;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(32'hCAFEF00D, 0, chk);
    send_byte(8'h11);
    send_byte(8'h22);
    // Restart with a byte in the same cycle: that byte must be dropped.
    start        = 1'b1;
    bus.rx_data  = 8'h33;
    bus.rx_valid = 1'b1;
    @(posedge clka);
    #1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    checks = checks + 1;
    if (busy !== 1'b1 || words_written !== 12'd0 || n_writes - w0 != 1) begin
      errors = errors + 1;
      $display("FAIL abort_status: busy=%b ww=%0d writes=%0d, required 1 0 1",
               busy, words_written, n_writes - w0);
    end
    // The loader must now be waiting for LEN_HI.
    chk = 8'h00;
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'hAABBCCDD, 0, chk);
    send_byte(chk);
    idle_cycles(2);
    checks = checks + 1;
    if (done !== 1'b1 || words_written !== 12'd1 || n_writes - w0 != 2 || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL abort_reload: done=%b ww=%0d writes=%0d pending=%0d, required 1 1 2 0",
               done, words_written, n_writes - w0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] chk = 8'h00;
    int         w0;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(32'h01020304, 0, chk);
    send_byte(8'h55);
    send_byte(8'h66);
    #3;
    rsta_n = 1'b0;
    #1;
    checks = checks + 1;
    if ({bus.wea, bus.addra, bus.dina, busy, done, error, words_written} !== '0) begin
      errors = errors + 1;
      $display("FAIL midreset_outputs: wea=%b addra=%0d dina=%h busy=%b done=%b error=%b ww=%0d, required all 0",
               bus.wea, bus.addra, bus.dina, busy, done, error, words_written);
    end
    idle_cycles(2);
    rsta_n = 1'b1;
    idle_cycles(1);
    w0 = n_writes;
    // Without start, a complete frame must be ignored.
    send_byte(8'h00);
    send_byte(8'h01);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i));
    idle_cycles(2);
    checks = checks + 1;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || n_writes != w0 || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL midreset_ignored: busy=%b done=%b error=%b writes=%0d pending=%0d, required 0 0 0 0 0",
               busy, done, error, n_writes - w0, exp_q.size());
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    n_writes     = 0;
    rsta_n       = 1'b0;
    start        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    test_reset();
    test_good_frame();
    test_bad_chk();
    test_bad_len(8'h00, 8'h00);
    test_bad_len(8'h08, 8'h01);
    test_full_memory();
    test_start_abort();
    test_reset_mid_load();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
